// File: rtl/replay_read_ctrl_pkg.sv
// Shared VLSU types for the replay read-side controller.
package replay_read_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REPLAY = 2'd2
  } replay_state_e;

endpackage

// File: rtl/replay_read_ctrl_if.sv
// Lane-facing valid/ready stream carrying operand words and pass markers.
interface replay_read_ctrl_if #(
  parameter int RD_DATA_WIDTH = 32
);
  logic                     valid_o;
  logic                     ready_i;
  logic [RD_DATA_WIDTH-1:0] data_o;
  logic                     pass_last_o;
  logic                     cmd_last_o;

  modport master (output valid_o, output data_o, output pass_last_o, output cmd_last_o,
                  input  ready_i);
  modport slave  (input  valid_o, input  data_o, input  pass_last_o, input  cmd_last_o,
                  output ready_i);
endinterface

// File: rtl/replay_read_ctrl.sv
// Drains a re-readable operand buffer to the lanes N times: pass 1 overlaps
// the load, later passes replay retained data; flushes the buffer at the end.
module replay_read_ctrl
  import replay_read_ctrl_pkg::*;
#(
  parameter int RD_DATA_WIDTH = 32,
  parameter int NR_LANES      = 4,
  parameter int DEPTH         = 8,
  parameter int PASS_W        = 4,
  localparam int LEN_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LEN_W-1:0]         cmd_len_i,
  input  logic [PASS_W-1:0]        cmd_passes_i,
  input  logic                     abort_i,
  input  logic                     fifo_push_i,
  output logic                     fifo_final_push_o,
  input  logic                     fifo_empty_i,
  input  logic [RD_DATA_WIDTH-1:0] fifo_data_i,
  output logic                     fifo_pop_o,
  output logic                     fifo_flush_o,
  replay_read_ctrl_if.master       lane_if,
  output logic                     done_o
);

  replay_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              loaded_q, loaded_d;
  logic              done_q, done_d;

  logic              valid;
  logic              pop;
  logic              abort_act;
  logic              rd_end;
  logic              final_pass;
  logic [LEN_W:0]    wr_sum;

  assign wr_sum     = {1'b0, wr_cnt_q} + (LEN_W+1)'(NR_LANES);
  assign rd_end     = (rd_cnt_q == len_q - LEN_W'(1));
  assign final_pass = (pass_cnt_q == passes_q - PASS_W'(1));
  assign abort_act  = abort_i & (state_q != IDLE);

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    passes_d          = passes_q;
    wr_cnt_d          = wr_cnt_q;
    rd_cnt_d          = rd_cnt_q;
    pass_cnt_d        = pass_cnt_q;
    loaded_d          = loaded_q;
    done_d            = 1'b0;
    cmd_ready_o       = 1'b0;
    valid             = 1'b0;
    fifo_final_push_o = 1'b0;
    fifo_flush_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          len_d      = cmd_len_i;
          passes_d   = (cmd_passes_i == '0) ? PASS_W'(1) : cmd_passes_i;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          pass_cnt_d = '0;
          loaded_d   = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // Holding the last pass-1 word until read-only mode is live makes the
        // buffer's read pointer wrap at len instead of reading past it.
        valid = ~fifo_empty_i & ~(rd_end & ~loaded_q);
        if (fifo_push_i && !loaded_q && !abort_i) begin
          wr_cnt_d          = wr_sum[LEN_W-1:0];
          fifo_final_push_o = (wr_sum >= {1'b0, len_q});
          loaded_d          = fifo_final_push_o;
        end
      end
      REPLAY: valid = 1'b1;
      default: state_d = IDLE;
    endcase

    if (abort_act) begin
      valid        = 1'b0;
      fifo_flush_o = 1'b1;
      state_d      = IDLE;
    end

    pop = valid & lane_if.ready_i;
    if (pop) begin
      if (rd_end) begin
        rd_cnt_d   = '0;
        pass_cnt_d = pass_cnt_q + PASS_W'(1);
        if (final_pass) begin
          fifo_flush_o = 1'b1;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = REPLAY;
        end
      end else begin
        rd_cnt_d = rd_cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      passes_q   <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pass_cnt_q <= '0;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      passes_q   <= passes_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      loaded_q   <= loaded_d;
      done_q     <= done_d;
    end
  end

  assign fifo_pop_o          = pop;
  assign done_o              = done_q;
  assign lane_if.valid_o     = valid;
  assign lane_if.data_o      = fifo_data_i;
  assign lane_if.pass_last_o = valid & rd_end;
  assign lane_if.cmd_last_o  = valid & rd_end & final_pass;

endmodule

// File: tb/tb_replay_read_ctrl.sv
// Randomized scoreboard bench for replay_read_ctrl with a behavioural buffer.
module tb_replay_read_ctrl;
  localparam int W  = 32;
  localparam int NR = 4;
  localparam int D  = 8;
  localparam int PW = 4;
  localparam int LW = $clog2(D + 1);

  typedef struct packed {
    logic [W-1:0] d;
    logic         pl;
    logic         cl;
    logic         p1;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len_i = '0;
  logic [PW-1:0] cmd_passes_i = '0;
  logic          abort_i = 1'b0;
  logic          fifo_push_i = 1'b0;
  logic          fifo_final_push_o;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_pop_o;
  logic          fifo_flush_o;
  logic          done_o;

  replay_read_ctrl_if #(.RD_DATA_WIDTH(W)) lif ();

  replay_read_ctrl #(.RD_DATA_WIDTH(W), .NR_LANES(NR), .DEPTH(D), .PASS_W(PW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_passes_i(cmd_passes_i), .abort_i(abort_i),
    .fifo_push_i(fifo_push_i), .fifo_final_push_o(fifo_final_push_o),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_pop_o(fifo_pop_o), .fifo_flush_o(fifo_flush_o),
    .lane_if(lif), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Behavioural re-readable buffer: plain FIFO while loading, wraps at len
  // and reports non-empty once in read-only mode.
  logic [W-1:0] src  [16];
  logic [W-1:0] bmem [16];
  logic [3:0]   widx, ridx, blen;
  logic         ro;

  assign fifo_empty = ~ro & (ridx == widx);
  assign fifo_data  = bmem[ridx];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      widx <= '0;
      ridx <= '0;
      ro   <= 1'b0;
    end else if (fifo_flush_o) begin
      widx <= '0;
      ridx <= '0;
      ro   <= 1'b0;
    end else begin
      if (fifo_push_i) begin
        for (int i = 0; i < NR; i++) bmem[widx + 4'(i)] <= src[widx + 4'(i)];
        widx <= widx + 4'(NR);
      end
      if (fifo_pop_o) ridx <= (ridx + 4'd1 == blen) ? 4'd0 : ridx + 4'd1;
      if (fifo_final_push_o) ro <= 1'b1;
    end
  end

  // Ready driver: always-ready or 50% random backpressure.
  bit rnd_mode = 1'b0;
  initial begin
    lif.ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lif.ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard state shared between driver and monitor.
  exp_t sb[$];
  bit   active = 0, loading = 0, done_pending = 0, finished = 0;
  int   pushed = 0, hs_count = 0, fp_cyc = -1, cyc = 0, cur_len = 0;

  always @(negedge clk) begin
    logic hs;
    exp_t e;
    if (rst_ni) begin
      cyc++;
      hs = lif.valid_o & lif.ready_i;
      chk1("done", done_o, done_pending);
      done_pending = 0;
      chk1("cmd_ready", cmd_ready_o, !active);
      chk1("pop_eq_handshake", fifo_pop_o, hs);
      chk1("final_push", fifo_final_push_o,
           active & loading & fifo_push_i & !abort_i & (pushed + NR >= cur_len));
      if (active && loading && fifo_push_i && !abort_i) begin
        pushed += NR;
        if (pushed >= cur_len) begin
          loading = 0;
          fp_cyc  = cyc;
        end
      end
      if (active && !abort_i && hs_count >= cur_len) chk1("no_gap", lif.valid_o, 1'b1);
      if (active && abort_i) begin
        chk1("abort_flush", fifo_flush_o, 1'b1);
        chk1("abort_no_pop", fifo_pop_o, 1'b0);
        sb.delete();
        active   = 0;
        loading  = 0;
        finished = 1;
      end else if (hs) begin
        chk1("word_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk32("data", lif.data_o, e.d);
          chk1("pass_last", lif.pass_last_o, e.pl);
          chk1("cmd_last", lif.cmd_last_o, e.cl);
          chk1("flush_at_end", fifo_flush_o, e.cl);
          if (e.p1) chk1("last_word_held", (fp_cyc >= 0) && (fp_cyc < cyc), 1'b1);
          hs_count++;
          if (e.cl) begin
            active       = 0;
            done_pending = 1;
            finished     = 1;
          end
        end
      end else begin
        chk1("no_flush", fifo_flush_o, 1'b0);
      end
      if (cmd_valid_i && cmd_ready_o) begin
        active   = 1;
        loading  = 1;
        pushed   = 0;
        hs_count = 0;
        fp_cyc   = -1;
      end
    end
  end

  task automatic do_reset_check();
    #2;
    rst_ni = 1'b0;
    #1;
    chk1("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk1("rst_valid", lif.valid_o, 1'b0);
    chk1("rst_pop", fifo_pop_o, 1'b0);
    chk1("rst_flush", fifo_flush_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_pass_last", lif.pass_last_o, 1'b0);
    chk1("rst_cmd_last", lif.cmd_last_o, 1'b0);
    chk1("rst_final_push", fifo_final_push_o, 1'b0);
    sb.delete();
    active = 0; loading = 0; done_pending = 0; finished = 1;
    fifo_push_i = 1'b0; abort_i = 1'b0; cmd_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic run_cmd(input int len, input int passes, input int gap_max,
                         input bit rnd, input int abort_at, input int rst_at);
    int eff, t, left, gap;
    exp_t e;
    rnd_mode = rnd;
    eff = (passes == 0) ? 1 : passes;
    for (int i = 0; i < len; i++) src[i] = $urandom;
    blen    = 4'(len);
    cur_len = len;
    for (int p = 0; p < eff; p++)
      for (int w = 0; w < len; w++) begin
        e.d  = src[w];
        e.pl = (w == len - 1);
        e.cl = (w == len - 1) && (p == eff - 1);
        e.p1 = (w == len - 1) && (p == 0);
        sb.push_back(e);
      end
    finished     = 0;
    cmd_len_i    = LW'(len);
    cmd_passes_i = PW'(passes);
    cmd_valid_i  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready_o && t < 50);
    if (!cmd_ready_o) begin
      $display("FAIL accept_timeout: cmd_ready_o stayed 0");
      n_cmp++; n_err++;
      report();
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    left = len / NR;
    gap  = $urandom_range(0, gap_max);
    t    = 0;
    forever begin
      if (finished) break;
      if (++t > 2000) begin
        $display("FAIL cmd_timeout: command never completed");
        n_cmp++; n_err++;
        report();
      end
      if (rst_at >= 0 && hs_count >= rst_at) begin
        do_reset_check();
        break;
      end
      if (abort_at >= 0 && hs_count == abort_at) abort_i = 1'b1;
      if (left > 0) begin
        if (gap == 0) begin
          fifo_push_i = 1'b1;
          left--;
          gap = $urandom_range(0, gap_max);
        end else begin
          gap--;
        end
      end
      @(posedge clk);
      #1;
      fifo_push_i = 1'b0;
      abort_i     = 1'b0;
    end
    chk32("sb_drained", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_cmd_ready", cmd_ready_o, 1'b1);
    chk1("reset_valid", lif.valid_o, 1'b0);
    chk1("reset_done", done_o, 1'b0);
    chk1("reset_flush", fifo_flush_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    run_cmd(8, 1, 0, 0, -1, -1);
    run_cmd(8, 3, 0, 0, -1, -1);
    run_cmd(4, 2, 0, 0, -1, -1);
    for (int k = 0; k < 3; k++) run_cmd(8, 2, 3, 1, -1, -1);
    run_cmd(8, 3, 0, 0, 10, -1);
    run_cmd(8, 2, 1, 0, -1, -1);
    run_cmd(8, 0, 1, 1, -1, -1);
    run_cmd(4, 0, 0, 0, -1, -1);
    run_cmd(4, 4, 2, 1, -1, -1);
    run_cmd(8, 5, 0, 0, -1, 12);
    run_cmd(8, 1, 2, 1, -1, -1);
    for (int k = 0; k < 8; k++)
      run_cmd(($urandom_range(0, 1) != 0) ? 8 : 4, $urandom_range(0, 4),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, -1);
    repeat (3) @(posedge clk);
    #1;
    report();
  end

endmodule
